inv_sub_bytes_ctrl: RTL and testbench
=====================================

Name: inv_sub_bytes_ctrl

Overview:
- Sequences the AES decryption InvSubBytes layer over a full 128-bit state using a reduced number of inverse S-box lookup lanes.
- Accepts one state over a valid/ready handshake and feeds LANES bytes per cycle through shared inv_sbox_unit instances.
- Assembles the substituted state in a register and presents it downstream over a valid/ready handshake.
- Sits between the AddRoundKey/InvShiftRows stage and the InvMixColumns stage of the decryption round datapath.

Parameters:
- LANES, 4, number of inv_sbox_unit instances, i.e. bytes substituted per cycle. Legal values are 1, 2, 4, 8 and 16; any other value is a fatal elaboration error.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  upstream has a state on in_state.
- in_ready  output  1  block can accept a state this cycle.
- in_state  input  128  ciphertext-side state; byte k = in_state[8k+7:8k], for k = 0..15.
- out_valid  output  1  out_state holds a completed substituted state.
- out_ready  input  1  downstream accepts out_state this cycle.
- out_state  output  128  substituted state; byte k = InvSbox(in_state byte k).
- busy  output  1  high whenever the FSM is not in IDLE.

Behaviour:
- Constants: NBEATS = 16/LANES; beat counter width = max(1, $clog2(NBEATS)).
- Reset (async, rst=1):
  - FSM goes to IDLE; beat counter = 0.
  - Work register and out_state = 128'h0.
  - out_valid = 0, busy = 0, in_ready = 1 once rst deasserts.
  - Reset mid-SUB or mid-DONE abandons the state silently; no out_valid pulse follows.
- FSM states:
  - IDLE: in_ready = 1. On in_valid, latch in_state into the work register, clear the beat counter, go to SUB.
  - SUB: on each cycle, beat b drives work bytes b*LANES .. b*LANES+LANES-1 into the lanes. The lane outputs are written back into the same byte positions at the clock edge, and the counter increments. On the edge with b = NBEATS-1, go to DONE. in_ready = 0.
  - DONE: out_valid = 1 and out_state = work register, both held stable until out_ready = 1.
    - out_ready & in_valid in the same cycle: complete the transfer, latch the new in_state, go directly to SUB (back-to-back, no IDLE bubble).
    - out_ready & !in_valid: go to IDLE.
- in_ready is combinational: (state==IDLE) | (state==DONE & out_ready).
- Latency, accept edge to out_valid high: NBEATS+1 cycles (LANES=4 gives 5; LANES=16 gives 2).
- Throughput with back-to-back traffic: one state per NBEATS+1 cycles.
- in_valid during SUB is ignored; upstream must hold the state until in_ready.
- out_state changes only on accept edges and SUB write-back edges. It is not a handshake-qualified value outside DONE.
- The lanes are purely combinational. There is no pipeline register inside them; the only registers are the work register and the FSM.

Decomposition:
- Add to the shared aes_pkg:
  - AES_STATE_BYTES = 16.
  - Typedef aes_state_t = logic [127:0].
  - Enum inv_sb_state_e {IDLE, SUB, DONE}.
- No new sub-module. Generate LANES instances of the existing inv_sbox_unit (inputByte/invByteSOut) with a per-beat byte-select mux in front and a demux behind.

Test Plan:
- Zero state: after reset, in_state = 128'h0 with in_valid pulse -> out_valid rises exactly 5 cycles after the accept edge (LANES=4), out_state = {16{8'h52}}.
- Ascending bytes: byte k = k (0x00..0x0F) -> out bytes 0..15 = 52 09 6A D5 30 36 A5 38 BF 40 A3 9E 81 F3 D7 FB.
- Round-trip identity: bytes alternating 0x63/0x7C -> output bytes alternating 0x00/0x01. Also sweep all 256 values across 16 states against a golden table.
- Backpressure: hold out_ready = 0 for 10 cycles in DONE -> out_valid stays 1, out_state is stable, in_ready = 0, a second in_valid is not accepted until out_ready = 1.
- Back-to-back: in_valid held high with two states, out_ready = 1 -> second accept on the same edge as the first output transfer, second out_valid 5 cycles later, no IDLE cycle in between.
- Reset mid-SUB: assert rst on beat 2 -> out_valid = 0, busy = 0, out_state = 0 immediately, and no output appears for the aborted state.
- Parameter sweep: repeat the ascending-bytes case at LANES = 1, 2, 16 -> latencies 17, 9, 2 cycles, identical out_state.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES datapath types and constants used across the decryption round stages.
package aes_pkg;

  localparam int AES_STATE_BYTES = 16;

  typedef logic [127:0] aes_state_t;

  typedef enum logic [1:0] {
    IDLE,
    SUB,
    DONE
  } inv_sb_state_e;

endpackage

// File: rtl/inv_sbox_unit.sv
// Combinational AES inverse S-box: inverse affine map followed by GF(2^8) inversion.
// Zero latency, no flow control.
module inv_sbox_unit (
  input  logic [7:0] inputByte,
  output logic [7:0] invByteSOut
);

  // Multiply in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // a^254 == a^-1 (and 0 maps to 0): build a^127 by square-and-multiply, then square.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] r;
    r = a;
    for (int i = 0; i < 6; i++) begin
      r = gf_mul(gf_mul(r, r), a);
    end
    return gf_mul(r, r);
  endfunction

  logic [7:0] unmixed;

  always_comb begin
    unmixed     = {inputByte[6:0], inputByte[7]}
                ^ {inputByte[4:0], inputByte[7:5]}
                ^ {inputByte[1:0], inputByte[7:2]}
                ^ 8'h05;
    invByteSOut = gf_inv(unmixed);
  end

endmodule

// File: rtl/inv_sub_bytes_ctrl.sv
// InvSubBytes over a 128-bit state using LANES shared inverse S-boxes, LANES bytes per beat.
// Accept-to-out_valid in 16/LANES+1 cycles; out_state held in DONE until out_ready.
module inv_sub_bytes_ctrl
  import aes_pkg::*;
#(
  parameter int LANES = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state,
  output logic         busy
);

  localparam int NBEATS = AES_STATE_BYTES / LANES;
  localparam int CW     = (NBEATS > 1) ? $clog2(NBEATS) : 1;

  generate
    if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
      $fatal(1, "inv_sub_bytes_ctrl: LANES must be 1, 2, 4, 8 or 16");
    end
  endgenerate

  inv_sb_state_e state, state_nxt;
  logic [CW-1:0] beat, beat_nxt;
  aes_state_t    work, work_nxt;
  logic [7:0]    lane_in  [LANES];
  logic [7:0]    lane_out [LANES];

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    inv_sbox_unit u_inv_sbox (
      .inputByte   (lane_in[g]),
      .invByteSOut (lane_out[g])
    );
  end

  // Beat b feeds bytes b*LANES .. b*LANES+LANES-1 into the lanes.
  always_comb begin
    for (int g = 0; g < LANES; g++) begin
      lane_in[g] = 8'h00;
      for (int b = 0; b < NBEATS; b++) begin
        if (beat == CW'(b)) lane_in[g] = work[8*(b*LANES+g) +: 8];
      end
    end
  end

  always_comb begin
    state_nxt = state;
    beat_nxt  = beat;
    work_nxt  = work;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          work_nxt  = in_state;
          beat_nxt  = '0;
          state_nxt = SUB;
        end
      end
      SUB: begin
        for (int g = 0; g < LANES; g++) begin
          for (int b = 0; b < NBEATS; b++) begin
            if (beat == CW'(b)) work_nxt[8*(b*LANES+g) +: 8] = lane_out[g];
          end
        end
        beat_nxt = beat + 1'b1;
        if (beat == CW'(NBEATS - 1)) begin
          beat_nxt  = '0;
          state_nxt = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
        // A new state arriving with the output transfer skips the IDLE bubble.
        if (out_ready) begin
          if (in_valid) begin
            work_nxt  = in_state;
            beat_nxt  = '0;
            state_nxt = SUB;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      beat  <= '0;
      work  <= '0;
    end else begin
      state <= state_nxt;
      beat  <= beat_nxt;
      work  <= work_nxt;
    end
  end

  assign out_state = work;
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_inv_sub_bytes_ctrl.sv
// Directed self-checking bench for inv_sub_bytes_ctrl (LANES=4 main instance plus 1/2/16 sweep).
module tb_inv_sub_bytes_ctrl;

  localparam logic [127:0] ASC_IN  = 128'h0f0e0d0c0b0a09080706050403020100;
  localparam logic [127:0] ASC_OUT = 128'hfbd7f3819ea340bf38a53630d56a0952;
  localparam logic [127:0] ALT_IN  = {8{16'h7c63}};
  localparam logic [127:0] ALT_OUT = {8{16'h0100}};

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [127:0] in_state = '0;
  logic         in_ready, out_valid, busy;
  logic [127:0] out_state;

  logic         sw_valid = 1'b0;
  logic         sw_ready = 1'b0;
  logic         r1, v1, b1, r2, v2, b2, r16, v16, b16;
  logic [127:0] o1, o2, o16;

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] isb [256];

  always #5 clk = ~clk;

  inv_sub_bytes_ctrl #(.LANES(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_state(in_state),
    .out_valid(out_valid), .out_ready(out_ready), .out_state(out_state), .busy(busy)
  );

  inv_sub_bytes_ctrl #(.LANES(1)) dut_l1 (
    .clk(clk), .rst(rst), .in_valid(sw_valid), .in_ready(r1), .in_state(in_state),
    .out_valid(v1), .out_ready(sw_ready), .out_state(o1), .busy(b1)
  );

  inv_sub_bytes_ctrl #(.LANES(2)) dut_l2 (
    .clk(clk), .rst(rst), .in_valid(sw_valid), .in_ready(r2), .in_state(in_state),
    .out_valid(v2), .out_ready(sw_ready), .out_state(o2), .busy(b2)
  );

  inv_sub_bytes_ctrl #(.LANES(16)) dut_l16 (
    .clk(clk), .rst(rst), .in_valid(sw_valid), .in_ready(r16), .in_state(in_state),
    .out_valid(v16), .out_ready(sw_ready), .out_state(o16), .busy(b16)
  );

  // Reference model: forward S-box from a brute-force field inverse, then inverted by table.
  function automatic logic [7:0] m_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] m_inv(input logic [7:0] a);
    if (a == 8'h00) return 8'h00;
    for (int c = 1; c < 256; c++) begin
      if (m_mul(a, 8'(c)) == 8'h01) return 8'(c);
    end
    return 8'h00;
  endfunction

  function automatic logic [7:0] m_sbox(input logic [7:0] x);
    logic [7:0] s = m_inv(x);
    return s ^ {s[6:0], s[7]} ^ {s[5:0], s[7:6]} ^ {s[4:0], s[7:5]} ^ {s[3:0], s[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [127:0] m_state(input logic [127:0] st);
    logic [127:0] r;
    for (int k = 0; k < 16; k++) r[8*k +: 8] = isb[st[8*k +: 8]];
    return r;
  endfunction

  // Called at a negedge with the DUT idle; returns at the negedge where out_valid is seen.
  task automatic send_and_wait(input logic [127:0] st, output int lat);
    int w = 0;
    in_state = st;
    in_valid = 1'b1;
    #1;
    while (!in_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 60) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic release_output();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    #1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_checks++; if (out_state !== 128'h0) begin n_fail++; $display("FAIL reset_out_state got=%h exp=0", out_state); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_zero_state();
    int lat;
    @(negedge clk);
    send_and_wait(128'h0, lat);
    n_checks++; if (lat != 5) begin n_fail++; $display("FAIL zero_latency got=%0d exp=5", lat); end
    n_checks++; if (out_state !== {16{8'h52}}) begin n_fail++; $display("FAIL zero_state got=%h exp=%h", out_state, {16{8'h52}}); end
    release_output();
    n_checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL zero_release got valid=%b busy=%b exp 0 0", out_valid, busy); end
  endtask

  task automatic test_ascending();
    int lat;
    send_and_wait(ASC_IN, lat);
    n_checks++; if (out_state !== ASC_OUT) begin n_fail++; $display("FAIL ascending got=%h exp=%h", out_state, ASC_OUT); end
    release_output();
  endtask

  task automatic test_roundtrip();
    int lat;
    logic [127:0] st;
    send_and_wait(ALT_IN, lat);
    n_checks++; if (out_state !== ALT_OUT) begin n_fail++; $display("FAIL roundtrip got=%h exp=%h", out_state, ALT_OUT); end
    release_output();
    for (int s = 0; s < 16; s++) begin
      for (int k = 0; k < 16; k++) st[8*k +: 8] = 8'(16*s + k);
      send_and_wait(st, lat);
      n_checks++;
      if (out_state !== m_state(st)) begin
        n_fail++; $display("FAIL sweep_%0d got=%h exp=%h", s, out_state, m_state(st));
      end
      release_output();
    end
  endtask

  task automatic test_backpressure();
    int lat;
    send_and_wait(ASC_IN, lat);
    in_state = {16{8'haa}};
    in_valid = 1'b1;
    #1;
    for (int i = 0; i < 10; i++) begin
      n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid_%0d got=%b exp=1", i, out_valid); end
      n_checks++; if (out_state !== ASC_OUT) begin n_fail++; $display("FAIL bp_state_%0d got=%h exp=%h", i, out_state, ASC_OUT); end
      n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready_%0d got=%b exp=0", i, in_ready); end
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_ready got=%b exp=1", in_ready); end
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b0;
    n_checks++; if (busy !== 1'b1 || out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_second_accept got busy=%b valid=%b exp 1 0", busy, out_valid); end
    lat = 1;
    while (!out_valid && lat < 60) begin
      @(negedge clk);
      lat++;
    end
    n_checks++; if (lat != 5) begin n_fail++; $display("FAIL bp_second_latency got=%0d exp=5", lat); end
    n_checks++; if (out_state !== m_state({16{8'haa}})) begin n_fail++; $display("FAIL bp_second_state got=%h exp=%h", out_state, m_state({16{8'haa}})); end
    release_output();
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    in_state  = ASC_IN;
    in_valid  = 1'b1;
    #1;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_first_ready got=%b exp=1", in_ready); end
    for (int c = 1; c <= 11; c++) begin
      @(negedge clk);
      if (c == 1) in_state = ALT_IN;
      #1;
      if (c == 5) begin
        n_checks++; if (out_valid !== 1'b1 || out_state !== ASC_OUT) begin n_fail++; $display("FAIL b2b_first_out got valid=%b state=%h exp 1 %h", out_valid, out_state, ASC_OUT); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_second_ready got=%b exp=1", in_ready); end
      end else if (c == 10) begin
        n_checks++; if (out_valid !== 1'b1 || out_state !== ALT_OUT) begin n_fail++; $display("FAIL b2b_second_out got valid=%b state=%h exp 1 %h", out_valid, out_state, ALT_OUT); end
        in_valid = 1'b0;
      end else if (c == 11) begin
        n_checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL b2b_idle got valid=%b busy=%b exp 0 0", out_valid, busy); end
      end else begin
        n_checks++; if (out_valid !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL b2b_sub_c%0d got valid=%b busy=%b exp 0 1", c, out_valid, busy); end
      end
    end
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid_sub();
    logic seen = 1'b0;
    @(negedge clk);
    in_state = ASC_IN;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_valid got=%b exp=0", out_valid); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy got=%b exp=0", busy); end
    n_checks++; if (out_state !== 128'h0) begin n_fail++; $display("FAIL midrst_state got=%h exp=0", out_state); end
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    repeat (12) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    out_ready = 1'b0;
    n_checks++; if (seen !== 1'b0) begin n_fail++; $display("FAIL midrst_no_output got=%b exp=0", seen); end
  endtask

  task automatic test_param_sweep();
    int l1 = 0, l2 = 0, l16 = 0;
    logic [127:0] s1 = '0, s2 = '0, s16 = '0;
    @(negedge clk);
    in_state = ASC_IN;
    sw_valid = 1'b1;
    @(negedge clk);
    sw_valid = 1'b0;
    for (int c = 1; c <= 25; c++) begin
      if (v1 && l1 == 0) begin l1 = c; s1 = o1; end
      if (v2 && l2 == 0) begin l2 = c; s2 = o2; end
      if (v16 && l16 == 0) begin l16 = c; s16 = o16; end
      @(negedge clk);
    end
    n_checks++; if (l1 != 17) begin n_fail++; $display("FAIL sweep_l1_latency got=%0d exp=17", l1); end
    n_checks++; if (l2 != 9) begin n_fail++; $display("FAIL sweep_l2_latency got=%0d exp=9", l2); end
    n_checks++; if (l16 != 2) begin n_fail++; $display("FAIL sweep_l16_latency got=%0d exp=2", l16); end
    n_checks++; if (s1 !== ASC_OUT) begin n_fail++; $display("FAIL sweep_l1_state got=%h exp=%h", s1, ASC_OUT); end
    n_checks++; if (s2 !== ASC_OUT) begin n_fail++; $display("FAIL sweep_l2_state got=%h exp=%h", s2, ASC_OUT); end
    n_checks++; if (s16 !== ASC_OUT) begin n_fail++; $display("FAIL sweep_l16_state got=%h exp=%h", s16, ASC_OUT); end
    sw_ready = 1'b1;
    @(negedge clk);
    sw_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int x = 0; x < 256; x++) isb[m_sbox(8'(x))] = 8'(x);
    repeat (2) @(negedge clk);
    test_reset();
    test_zero_state();
    test_ascending();
    test_roundtrip();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_sub();
    test_param_sweep();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
